// File: rtl/xy_sequencer.sv
// rtl/xy_sequencer.sv - rate-divided X/Y operand and select sequencer for the mux/HEX path
//
// Purpose: a down-counting divider produces a one-cycle tick every DIV_MAX+1
// enabled clocks. A two-state show sequencer alternates Sel between X and Y
// on each tick and steps the operands (X up, Y down) every second tick.
// A rising edge on load presets the operands and restarts the period.
//
// Ports:
//   CLOCK_50  in   1  system clock, rising edge
//   resetn    in   1  asynchronous active-low reset
//   enable    in   1  1 = divider and sequencer run, 0 = frozen
//   load      in   1  level; its rising edge presets X/Y and restarts the divider
//   load_x    in   2  preset value for X
//   load_y    in   2  preset value for Y
//   hold      in   1  1 = Sel frozen, 0 = Sel alternates each tick
//   X         out  2  operand A
//   Y         out  2  operand B
//   Sel       out  1  mux select (0 = X shown, 1 = Y shown)
//   tick      out  1  one-cycle pulse per divider expiry

module xy_sequencer #(
  parameter int DIV_MAX = 49999999,
  parameter int CNT_W   = 26
) (
  input  logic       CLOCK_50,
  input  logic       resetn,
  input  logic       enable,
  input  logic       load,
  input  logic [1:0] load_x,
  input  logic [1:0] load_y,
  input  logic       hold,
  output logic [1:0] X,
  output logic [1:0] Y,
  output logic       Sel,
  output logic       tick
);

  typedef enum logic {
    SHOW_X = 1'b0,
    SHOW_Y = 1'b1
  } state_t;

  localparam logic [CNT_W-1:0] CNT_RELOAD = CNT_W'(DIV_MAX);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             tick_q, tick_d;
  state_t           state_q, state_d;
  logic             sel_q, sel_d;
  logic [1:0]       x_q, x_d;
  logic [1:0]       y_q, y_d;
  logic             load_q, load_d;

  logic load_pulse;
  logic expiry;

  assign load_pulse = load & ~load_q;
  assign expiry     = enable & (cnt_q == '0);

  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) begin
      cnt_q   <= CNT_RELOAD;
      tick_q  <= 1'b0;
      state_q <= SHOW_X;
      sel_q   <= 1'b0;
      x_q     <= 2'd0;
      y_q     <= 2'd3;
      load_q  <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      tick_q  <= tick_d;
      state_q <= state_d;
      sel_q   <= sel_d;
      x_q     <= x_d;
      y_q     <= y_d;
      load_q  <= load_d;
    end
  end

  always_comb begin
    cnt_d   = cnt_q;
    tick_d  = 1'b0;
    state_d = state_q;
    sel_d   = sel_q;
    x_d     = x_q;
    y_d     = y_q;
    load_d  = load;

    if (load_pulse) begin
      // Load wins over a coincident expiry; that tick is dropped and the
      // period restarts from a full reload.
      x_d     = load_x;
      y_d     = load_y;
      state_d = SHOW_X;
      sel_d   = 1'b0;
      cnt_d   = CNT_RELOAD;
    end else if (expiry) begin
      cnt_d  = CNT_RELOAD;
      tick_d = 1'b1;
      if (!hold) begin
        case (state_q)
          SHOW_X: begin
            state_d = SHOW_Y;
            sel_d   = 1'b1;
          end
          SHOW_Y: begin
            // 2-bit wrap is intended: X 3->0, Y 0->3.
            state_d = SHOW_X;
            sel_d   = 1'b0;
            x_d     = x_q + 2'd1;
            y_d     = y_q - 2'd1;
          end
          default: begin
            state_d = SHOW_X;
            sel_d   = 1'b0;
          end
        endcase
      end
    end else if (enable) begin
      cnt_d = cnt_q - CNT_W'(1);
    end
  end

  assign X    = x_q;
  assign Y    = y_q;
  assign Sel  = sel_q;
  assign tick = tick_q;

endmodule

// File: tb/tb_xy_sequencer.sv
// tb/tb_xy_sequencer.sv - self-checking bench for xy_sequencer with a period/phase reference model

module tb_xy_sequencer;

  localparam int DIV_MAX = 3;
  localparam int PERIOD  = DIV_MAX + 1;

  logic       clk;
  logic       resetn;
  logic       enable;
  logic       load;
  logic [1:0] load_x;
  logic [1:0] load_y;
  logic       hold;
  logic [1:0] X;
  logic [1:0] Y;
  logic       Sel;
  logic       tick;

  int vectors;
  int miscompares;

  // Reference model: counts enabled cycles since the last restart and
  // fires a tick when a full period has elapsed.
  int m_x, m_y, m_sel, m_tick, m_elapsed, m_prev_load;

  xy_sequencer #(.DIV_MAX(DIV_MAX), .CNT_W(4)) dut (
    .CLOCK_50 (clk),
    .resetn   (resetn),
    .enable   (enable),
    .load     (load),
    .load_x   (load_x),
    .load_y   (load_y),
    .hold     (hold),
    .X        (X),
    .Y        (Y),
    .Sel      (Sel),
    .tick     (tick)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input int obs, input int exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_x = 0; m_y = 3; m_sel = 0; m_tick = 0; m_elapsed = 0; m_prev_load = 0;
  endtask

  task automatic model_step();
    int edge_seen;
    edge_seen   = (load && !m_prev_load) ? 1 : 0;
    m_prev_load = load ? 1 : 0;
    m_tick      = 0;
    if (edge_seen != 0) begin
      m_x = int'(load_x); m_y = int'(load_y); m_sel = 0; m_elapsed = 0;
    end else if (enable) begin
      m_elapsed++;
      if (m_elapsed == PERIOD) begin
        m_elapsed = 0;
        m_tick    = 1;
        if (!hold) begin
          if (m_sel == 1) begin
            m_x = (m_x + 1) % 4;
            m_y = (m_y + 3) % 4;
          end
          m_sel = 1 - m_sel;
        end
      end
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_step();
    #1;
    check("model_X", int'(X), m_x);
    check("model_Y", int'(Y), m_y);
    check("model_Sel", int'(Sel), m_sel);
    check("model_tick", int'(tick), m_tick);
  endtask

  initial begin
    int tick_count;
    int guard;
    vectors = 0; miscompares = 0;
    resetn = 1'b0; enable = 1'b1; load = 1'b0; load_x = 2'd0; load_y = 2'd0; hold = 1'b0;
    model_reset();

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_X", int'(X), 0);
    check("rst_Y", int'(Y), 3);
    check("rst_Sel", int'(Sel), 0);
    check("rst_tick", int'(tick), 0);
    resetn = 1'b1;

    // First 16 cycles after release
    for (int c = 1; c <= 16; c++) begin
      step();
      if (c == 3)  check("no_tick_c3", int'(tick), 0);
      if (c == 4)  begin check("tick_c4", int'(tick), 1); check("sel_c4", int'(Sel), 1); end
      if (c == 8)  begin check("X_c8", int'(X), 1); check("Y_c8", int'(Y), 2); check("sel_c8", int'(Sel), 0); end
      if (c == 12) check("sel_c12", int'(Sel), 1);
      if (c == 16) begin check("X_c16", int'(X), 2); check("Y_c16", int'(Y), 1); check("tick_c16", int'(tick), 1); end
    end

    // Eight full X/Y cycles, including wrap
    tick_count = 0;
    for (int c = 0; c < 8 * 2 * PERIOD; c++) begin
      step();
      if (tick) tick_count++;
    end
    check("wrap_tick_count", tick_count, 16);
    check("wrap_X", int'(X), 2);
    check("wrap_Y", int'(Y), 1);

    // Hold while Sel=1
    guard = 0;
    while (m_sel != 1 && guard < 20) begin step(); guard++; end
    check("hold_reach_sel1", m_sel, 1);
    hold = 1'b1;
    tick_count = 0;
    for (int c = 0; c < 3 * PERIOD; c++) begin
      step();
      if (tick) tick_count++;
      check("hold_sel_stays1", int'(Sel), 1);
    end
    check("hold_tick_count", tick_count, 3);
    hold = 1'b0;
    for (int c = 0; c < PERIOD; c++) step();
    check("unhold_sel0", int'(Sel), 0);

    // Load held high for 5 cycles
    load_x = 2'd2; load_y = 2'd1; load = 1'b1;
    step();
    check("load_X", int'(X), 2);
    check("load_Y", int'(Y), 1);
    check("load_Sel", int'(Sel), 0);
    for (int c = 1; c <= 4; c++) begin
      step();
      if (c == 4) check("load_tick_after4", int'(tick), 1);
      if (c == 4) check("load_single_sel", int'(Sel), 1);
    end
    load = 1'b0;
    step();

    // Load coincident with expiry
    guard = 0;
    while (m_elapsed != DIV_MAX && guard < 20) begin step(); guard++; end
    check("expiry_align", m_elapsed, DIV_MAX);
    load_x = 2'd1; load_y = 2'd2; load = 1'b1;
    step();
    check("ldexp_tick", int'(tick), 0);
    check("ldexp_Sel", int'(Sel), 0);
    check("ldexp_X", int'(X), 1);
    load = 1'b0;
    step();

    // Enable low for 10 cycles mid-period
    enable = 1'b0;
    for (int c = 0; c < 10; c++) step();
    enable = 1'b1;
    for (int c = 0; c < 2 * PERIOD; c++) step();

    // Randomized traffic
    for (int c = 0; c < 400; c++) begin
      enable = ($urandom_range(0, 7) != 0);
      hold   = ($urandom_range(0, 3) == 0);
      load   = ($urandom_range(0, 19) == 0);
      load_x = 2'($urandom_range(0, 3));
      load_y = 2'($urandom_range(0, 3));
      step();
    end
    enable = 1'b1; hold = 1'b0; load = 1'b0;
    step();

    // Async reset while Sel=1, X=3
    load_x = 2'd3; load_y = 2'd0; load = 1'b1;
    step();
    load = 1'b0;
    guard = 0;
    while (m_sel != 1 && guard < 20) begin step(); guard++; end
    check("pre_rst_sel", int'(Sel), 1);
    check("pre_rst_X", int'(X), 3);
    #2;
    resetn = 1'b0;
    #1;
    model_reset();
    check("arst_X", int'(X), 0);
    check("arst_Y", int'(Y), 3);
    check("arst_Sel", int'(Sel), 0);
    check("arst_tick", int'(tick), 0);
    @(negedge clk);
    resetn = 1'b1;
    for (int c = 1; c <= 4; c++) begin
      step();
      if (c == 4) check("arst_tick_c4", int'(tick), 1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/xy_sequencer.md
Name: xy_sequencer

Overview:
- Upstream stage for the 2-bit X/Y mux plus 7-segment display path.
- Drives the two 2-bit operands (X, Y) and the select line (Sel), so the HEX digit changes on its own at a human-visible rate.
- The operands come from a rate-divided tick and a two-state show sequencer.
- A load input lets switches preset the operands.

Parameters:
- DIV_MAX, 49999999, divider reload value; tick period = DIV_MAX+1 enabled clocks (1 Hz at 50 MHz).
- CNT_W, 26, divider counter width; must satisfy 2^CNT_W > DIV_MAX.

Ports:
- CLOCK_50  in  1  system clock, all state on rising edge.
- resetn  in  1  asynchronous, active-low reset.
- enable  in  1  high = divider runs; low = divider and sequencer frozen.
- load  in  1  synchronous level; rising edge requests preset.
- load_x  in  2  preset value for X.
- load_y  in  2  preset value for Y.
- hold  in  1  1 = Sel frozen at current value; 0 = Sel alternates each tick.
- X  out  2  operand A to mux.
- Y  out  2  operand B to mux.
- Sel  out  1  mux select (0 = X shown, 1 = Y shown).
- tick  out  1  one-cycle pulse on each divider expiry.

Behaviour:
- Reset (resetn=0, asynchronous, takes effect immediately):
  - cnt=DIV_MAX, tick=0, state=SHOW_X, Sel=0, X=2'd0, Y=2'd3, load_q=0.
  - All outputs are registered.
- Divider:
  - When enable=1 and cnt!=0: cnt decrements by 1.
  - When enable=1 and cnt==0: cnt reloads to DIV_MAX and tick=1 for exactly the following cycle.
  - When enable=0: cnt holds and tick=0.
  - The first tick after reset comes DIV_MAX+1 enabled cycles after release, then every DIV_MAX+1 enabled cycles.
- Load edge detect:
  - load_q registers load every cycle.
  - load_pulse = load & ~load_q.
  - Holding load high produces exactly one load.
- Load action (registered on the clock of load_pulse, independent of enable):
  - X=load_x, Y=load_y, state=SHOW_X, Sel=0, cnt=DIV_MAX, tick=0.
  - Load has priority over a coincident tick; that tick is discarded.
- State machine, advanced only on cycles where the internal expiry (enable=1, cnt==0) occurs:
  - SHOW_X -> SHOW_Y: Sel=1. Skipped if hold=1: stay SHOW_X, Sel stays 0.
  - SHOW_Y -> SHOW_X: Sel=0, X=X+1 mod 4, Y=Y-1 mod 4. Skipped if hold=1: stay SHOW_Y, Sel stays 1, X and Y unchanged.
  - Wrap-around: X 3->0, Y 0->3; the 2-bit truncation is intended.
- Timing: X, Y and Sel update in the same cycle tick asserts, i.e. 1 cycle after the expiry.
- Mid-operation reset: every register returns to its reset value immediately; no pending load or tick survives.
- enable toggling: deasserting enable for N cycles stretches the current period by exactly N cycles.

Test Plan:
- Reset release, DIV_MAX=3, enable=1, hold=0:
  - tick pulses at cycles 4, 8, 12, 16 after release.
  - Sel sequence is 1, 0, 1, 0.
  - (X,Y) goes (0,3) -> (1,2) at cycle 8 -> (2,1) at cycle 16.
- Run 8 full X/Y cycles: X and Y wrap as X=3 -> 0 and Y=0 -> 3, with no glitch on the tick count.
- Hold test:
  - Set hold=1 while Sel=1: Sel stays 1 and X, Y stay constant across 3 ticks.
  - Release hold: on the next tick, Sel goes to 0 and X increments.
- Load test:
  - Drive load_x=2, load_y=1 and hold load high for 5 cycles.
  - One load only: X=2, Y=1, Sel=0, divider restarts with the next tick 4 cycles later.
  - Load asserted on the expiry cycle: no tick, state stays SHOW_X.
- enable=0 for 10 cycles mid-period: tick is delayed by exactly 10 cycles and outputs are frozen meanwhile.
- Assert resetn=0 asynchronously between clock edges while Sel=1, X=3:
  - Outputs go to X=0, Y=3, Sel=0, tick=0 immediately.
  - First tick comes 4 cycles after release.
